// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM/owner enums and default widths for the SRAM port arbiter.
package sram_arb_pkg;
  localparam int DEF_ADDR_WIDTH = 25;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: 2-way grant generator; round-robin with SRAM_ARB_RR_EN, otherwise data-first priority.
module sram_arb_grant
  import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic clock,
  input  logic reset,
`endif
  input  logic en,
  input  logic i_valid,
  input  logic d_valid,
  output logic gnt_i,
  output logic gnt_d
);
`ifdef SRAM_ARB_RR_EN
  owner_e last_q, last_d;
  // On conflict the requester not granted last wins; reset favours D.
  assign gnt_d = en & d_valid & (~i_valid | (last_q == OWN_I));
  assign gnt_i = en & i_valid & ~gnt_d;
  assign last_d = gnt_d ? OWN_D : gnt_i ? OWN_I : last_q;
  always_ff @(posedge clock) last_q <= reset ? OWN_I : last_d;
`else
  assign gnt_d = en & d_valid;
  assign gnt_i = en & i_valid & ~d_valid;
`endif
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between instruction reads and data reads/writes.
// Arbitration policy selected by SRAM_ARB_RR_EN (round-robin) or fixed data-first when undefined.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_we,
  input  logic [NUM_WMASKS-1:0] d_req_wmask,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  input  logic                  d_rsp_ready,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [DATA_WIDTH-1:0] i_rsp_data_q, d_rsp_data_q;
  logic gnt_i, gnt_d, hs_rd, own_rdy;
  sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clock  (clock),
    .reset  (reset),
`endif
    .en     ((state_q == IDLE) & ~reset),
    .i_valid(i_req_valid),
    .d_valid(d_req_valid),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );
  assign i_req_ready = gnt_i;
  assign d_req_ready = gnt_d;
  assign hs_rd = gnt_i | (gnt_d & ~d_req_we);
  assign own_rdy = (owner_q == OWN_D) ? d_rsp_ready : i_rsp_ready;
  assign sram_csb = ~(gnt_i | gnt_d);
  assign sram_web = ~(gnt_d & d_req_we);
  assign sram_wmask = (gnt_d & d_req_we) ? d_req_wmask : '0;
  assign sram_addr = gnt_d ? d_req_addr : i_req_addr;
  assign sram_din = d_req_wdata;
  assign i_rsp_valid = (state_q == RESP) & (owner_q == OWN_I);
  assign d_rsp_valid = (state_q == RESP) & (owner_q == OWN_D);
  assign i_rsp_data = i_rsp_data_q;
  assign d_rsp_data = d_rsp_data_q;
  always_comb begin
    state_d = (state_q == IDLE) ? (hs_rd ? WAIT : IDLE) :
              (state_q == WAIT) ? RESP : (own_rdy ? IDLE : RESP);
    owner_d = hs_rd ? (gnt_d ? OWN_D : OWN_I) : owner_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      i_rsp_data_q <= '0;
      d_rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      // SRAM read data is valid during WAIT; capture it for the owner only.
      if (state_q == WAIT && owner_q == OWN_D) d_rsp_data_q <= sram_dout;
      if (state_q == WAIT && owner_q == OWN_I) i_rsp_data_q <= sram_dout;
    end
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane write-mask width.
REQ-004 SHALL have port clock, input, 1: single clock; SRAM port 0 clock is the same net.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports i_req_valid (input, 1), i_req_ready (output, 1) and i_req_addr (input, ADDR_WIDTH): instruction read request.
REQ-007 SHALL have ports i_rsp_valid (output, 1), i_rsp_ready (input, 1) and i_rsp_data (output, DATA_WIDTH): instruction response.
REQ-008 SHALL have ports d_req_valid (input, 1), d_req_ready (output, 1), d_req_addr (input, ADDR_WIDTH), d_req_we (input, 1), d_req_wmask (input, NUM_WMASKS) and d_req_wdata (input, DATA_WIDTH): data request.
REQ-009 SHALL have ports d_rsp_valid (output, 1), d_rsp_ready (input, 1) and d_rsp_data (output, DATA_WIDTH): data read response.
REQ-010 SHALL have ports sram_csb (output, 1, active-low), sram_web (output, 1, active-low write), sram_wmask (output, NUM_WMASKS), sram_addr (output, ADDR_WIDTH) and sram_din (output, DATA_WIDTH): SRAM port 0 drive.
REQ-011 SHALL have port sram_dout, input, DATA_WIDTH: SRAM port 0 read data.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-013 SHALL assert x_req_ready only in IDLE, and only for the granted requester.
REQ-014 SHALL drive all sram_* outputs combinationally in the handshake cycle: csb=0, web=~we (instruction: web=1), addr, wmask (reads: 0), din.
REQ-015 SHALL drive csb=1, web=1 and wmask=0 in every non-handshake cycle; addr and din are don't-care.
REQ-016 SHALL treat an accepted read as IDLE->WAIT and record its owner (I or D).
REQ-017 SHALL transition WAIT->RESP unconditionally, registering sram_dout into the owner's rsp_data at that edge.
REQ-018 SHALL hold the owner's rsp_valid high in RESP with stable rsp_data until rsp_ready, then move to IDLE; the non-owner rsp_valid stays 0.
REQ-019 SHALL make read latency exactly 2 cycles from handshake edge to rsp_valid; minimum read occupancy is 3 cycles.
REQ-020 SHALL complete an accepted data write with no response and stay in IDLE, so back-to-back writes are accepted every cycle.
REQ-021 SHALL require requesters to hold valid and payload stable until ready; the arbiter never retracts a grant within a cycle.
REQ-022 SHALL grant exactly one requester when both valid in IDLE, per REQ-027/REQ-028.
REQ-023 SHALL leave the SRAM deselected and assert no ready when neither requester is valid.

Reset
REQ-024 SHALL, on reset, set the state to IDLE, both rsp_valid to 0, both rsp_data to 0, the owner to D, and the round-robin pointer to favour D.
REQ-025 SHALL abandon any in-flight read on reset mid-operation with no response; outputs follow REQ-015 during and after reset.
REQ-026 SHALL keep all ready outputs at 0 while reset is high.

Configuration
REQ-027 SHALL, with SRAM_ARB_RR_EN defined, use round-robin arbitration: on conflict, grant the requester not granted last; the pointer updates on every accepted request.
REQ-028 SHALL, without SRAM_ARB_RR_EN, use fixed priority: data wins over instruction; no pointer state exists.

Structure
REQ-029 SHALL take from shared package sram_arb_pkg: the state enum (IDLE/WAIT/RESP), the owner enum (OWN_I/OWN_D) and default width constants.
REQ-030 SHALL instantiate sub-module sram_arb_grant, a 2-way grant generator holding the macro-dependent logic; it SHALL contain no other sub-modules.

Verification
REQ-031 SHALL cover: I read addr 0x10 with SRAM word 0xDEADBEEF -> i_rsp_valid 2 cycles after handshake, data 0xDEADBEEF.
REQ-032 SHALL cover: D write addr 0x4, wmask 0b0011, wdata 0x12345678 over 0xFFFFFFFF, then D read 0x4 -> 0xFFFF5678.
REQ-033 SHALL cover: both valid in IDLE for 4 requests -> grants alternate D,I,D,I (RR_EN) or D,D,D,D (no macro).
REQ-034 SHALL cover: i_rsp_ready held 0 for 5 cycles in RESP -> i_rsp_valid and data stable, no new grant, csb=1.
REQ-035 SHALL cover: reset asserted in WAIT -> next cycle IDLE, rsp_valid=0, csb=1, and the subsequent read returns correct data.
REQ-036 SHALL cover: 3 consecutive D writes -> d_req_ready=1 each cycle and csb=0, web=0 each cycle.
